// File: rtl/frame_stream_tx.sv
// Frame buffer and burst sender for the FFT serial load port: collects N samples
// from a ready/valid source, then writes them gap-free as new_data/addr/data.
module frame_stream_tx #(
  parameter int N            = 16,
  parameter int BIT_REVERSE  = 0,
  parameter int DONE_TIMEOUT = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [31:0]          s_real,
  input  logic [31:0]          s_imag,
  output logic                 new_data,
  output logic [$clog2(N)-1:0] addr,
  output logic [31:0]          data_real,
  output logic [31:0]          data_imag,
  input  logic                 done,
  output logic                 frame_sent,
  output logic                 timeout,
  output logic                 busy
);

  localparam int AW = $clog2(N);
  localparam int TW = $clog2(DONE_TIMEOUT + 1);
  localparam logic [AW-1:0] LAST_IDX  = AW'(N - 1);
  localparam logic [TW-1:0] LAST_WAIT = TW'(DONE_TIMEOUT - 1);

  typedef enum logic [1:0] {FILL, START, SEND, WAIT_DONE} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [TW-1:0]   wcnt_q, wcnt_d;
  logic            s_ready_q, s_ready_d;
  logic            new_data_q, new_data_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [31:0]     re_q, re_d;
  logic [31:0]     im_q, im_d;
  logic            frame_sent_q, frame_sent_d;
  logic            timeout_q, timeout_d;
  logic            busy_q, busy_d;
  logic            wr_en;
  logic [AW-1:0]   idx_nxt;

  logic [31:0] mem_re [N];
  logic [31:0] mem_im [N];

  function automatic logic [AW-1:0] map_addr(input logic [AW-1:0] i);
    logic [AW-1:0] r;
    r = i;
    if (BIT_REVERSE != 0)
      for (int b = 0; b < AW; b++) r[b] = i[AW-1-b];
    return r;
  endfunction

  assign idx_nxt = idx_q + 1'b1;

  // Outputs are registered from the next state, so each output flop already
  // shows the value belonging to the cycle the FSM is entering.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    wcnt_d       = wcnt_q;
    s_ready_d    = 1'b0;
    new_data_d   = 1'b0;
    addr_d       = '0;
    re_d         = '0;
    im_d         = '0;
    frame_sent_d = 1'b0;
    timeout_d    = timeout_q;
    busy_d       = 1'b1;
    wr_en        = 1'b0;
    case (state_q)
      FILL: begin
        s_ready_d = 1'b1;
        busy_d    = 1'b0;
        if (s_valid && s_ready_q) begin
          wr_en = 1'b1;
          if (cnt_q == LAST_IDX) begin
            cnt_d      = '0;
            state_d    = START;
            s_ready_d  = 1'b0;
            new_data_d = 1'b1;
            busy_d     = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      START: begin
        state_d = SEND;
        idx_d   = '0;
        addr_d  = map_addr('0);
        re_d    = mem_re[0];
        im_d    = mem_im[0];
      end
      SEND: begin
        if (idx_q == LAST_IDX) begin
          state_d = WAIT_DONE;
          wcnt_d  = '0;
        end else begin
          idx_d  = idx_nxt;
          addr_d = map_addr(idx_nxt);
          re_d   = mem_re[idx_nxt];
          im_d   = mem_im[idx_nxt];
        end
      end
      WAIT_DONE: begin
        if (done) begin
          frame_sent_d = 1'b1;
          state_d      = FILL;
          s_ready_d    = 1'b1;
          busy_d       = 1'b0;
        end else if (wcnt_q == LAST_WAIT) begin
          timeout_d = 1'b1;
          state_d   = FILL;
          s_ready_d = 1'b1;
          busy_d    = 1'b0;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      default: begin
        state_d   = FILL;
        s_ready_d = 1'b1;
        busy_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= FILL;
      cnt_q        <= '0;
      idx_q        <= '0;
      wcnt_q       <= '0;
      s_ready_q    <= 1'b1;
      new_data_q   <= 1'b0;
      addr_q       <= '0;
      re_q         <= '0;
      im_q         <= '0;
      frame_sent_q <= 1'b0;
      timeout_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      wcnt_q       <= wcnt_d;
      s_ready_q    <= s_ready_d;
      new_data_q   <= new_data_d;
      addr_q       <= addr_d;
      re_q         <= re_d;
      im_q         <= im_d;
      frame_sent_q <= frame_sent_d;
      timeout_q    <= timeout_d;
      busy_q       <= busy_d;
    end
  end

  // Sample storage has no reset; a partial frame is simply overwritten.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_re[cnt_q] <= s_real;
      mem_im[cnt_q] <= s_imag;
    end
  end

  assign s_ready    = s_ready_q;
  assign new_data   = new_data_q;
  assign addr       = addr_q;
  assign data_real  = re_q;
  assign data_imag  = im_q;
  assign frame_sent = frame_sent_q;
  assign timeout    = timeout_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_frame_stream_tx.sv
// Directed bench for frame_stream_tx: linear and bit-reversed instances share
// stimulus; a negedge monitor checks bursts, latencies and status pulses.
module tb_frame_stream_tx;
  localparam int N = 16;

  logic clk = 1'b0;
  logic rst, s_valid, done;
  logic [31:0] s_real, s_imag;

  logic s_ready0, new_data0, fs0, to0, busy0;
  logic [3:0] addr0;
  logic [31:0] dre0, dim0;
  logic s_ready1, new_data1, fs1, to1, busy1;
  logic [3:0] addr1;
  logic [31:0] dre1, dim1;

  frame_stream_tx #(.N(N), .BIT_REVERSE(0), .DONE_TIMEOUT(8)) u_dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready0),
    .s_real(s_real), .s_imag(s_imag), .new_data(new_data0), .addr(addr0),
    .data_real(dre0), .data_imag(dim0), .done(done), .frame_sent(fs0),
    .timeout(to0), .busy(busy0));

  frame_stream_tx #(.N(N), .BIT_REVERSE(1), .DONE_TIMEOUT(8)) u_dut_br (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready1),
    .s_real(s_real), .s_imag(s_imag), .new_data(new_data1), .addr(addr1),
    .data_real(dre1), .data_imag(dim1), .done(done), .frame_sent(fs1),
    .timeout(to1), .busy(busy1));

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  int cyc = 0, acc_cyc = 0, k = 0;
  int nd_cnt = 0, fs_cnt = 0, nd_cyc = 0, bi = 0;
  bit in_burst = 0, b2b = 0;
  logic to_prev = 1'b0;
  logic [63:0] fq[$];
  logic [63:0] frame [N];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] brev(input int i);
    logic [3:0] r;
    for (int b = 0; b < 4; b++) r[b] = i[3-b];
    return r;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst) begin
      in_burst = 0;
      to_prev  = 1'b0;
    end else begin
      if (in_burst) begin
        chk("addr_lin", addr0, bi[3:0]);
        chk("addr_rev", addr1, brev(bi));
        chk("data_lin", {dre0, dim0}, frame[bi]);
        chk("data_rev", {dre1, dim1}, frame[bi]);
        chk("send_flags", {s_ready0, busy0, s_ready1, busy1}, 4'b0101);
        bi++;
        if (bi == N) in_burst = 0;
      end else begin
        chk("idle_addr", {addr0, addr1}, 0);
        chk("idle_data", {dre0 | dre1, dim0 | dim1}, 0);
      end
      if (new_data0) begin
        nd_cnt++;
        chk("nd_lat", cyc, acc_cyc);
        chk("fill_n", fq.size(), N);
        chk("nd_rev", new_data1, 1);
        if (b2b && nd_cnt > 1) chk("nd_period", cyc - nd_cyc, 2 * N + 2);
        nd_cyc = cyc;
        for (int i = 0; i < N; i++) frame[i] = (i < fq.size()) ? fq[i] : 64'hx;
        fq.delete();
        in_burst = 1;
        bi = 0;
      end
      if (fs0) begin
        fs_cnt++;
        chk("fs_lat", cyc - nd_cyc, N + 2);
        chk("fs_rev", fs1, 1);
      end
      if (to0 && !to_prev) chk("to_lat", cyc - nd_cyc, N + 1 + 8);
      to_prev = to0;
    end
  end

  // Drive one cycle's inputs; the sample is consumed at the next posedge if ready.
  task automatic step(input logic v);
    @(negedge clk);
    s_valid = v;
    s_real  = 32'(k);
    s_imag  = 32'(-k);
    if (v && s_ready0) begin
      fq.push_back({s_real, s_imag});
      k++;
      acc_cyc = cyc + 1;
    end
  endtask

  task automatic wait_nd(input int target, input logic v);
    for (int i = 0; i < 200 && nd_cnt < target; i++) step(v);
    chk("reach_nd", nd_cnt >= target, 1);
  endtask

  task automatic wait_fs(input int target);
    for (int i = 0; i < 200 && fs_cnt < target; i++) step(1'b0);
    chk("reach_fs", fs_cnt >= target, 1);
  endtask

  initial begin
    rst = 1'b1; s_valid = 1'b0; done = 1'b1; s_real = '0; s_imag = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", {s_ready0, s_ready1}, 2'b11);
    chk("rst_outs", {new_data0, fs0, to0, busy0, new_data1, fs1, to1, busy1}, 0);
    chk("rst_data", {addr0, dre0, dim0}, 0);
    #2 rst = 1'b0;

    // Back-to-back frames with s_valid held high
    b2b = 1;
    for (int i = 0; i < 70; i++) step(1'b1);
    b2b = 0;
    chk("b2b_frames", nd_cnt, 2);

    // Sparse s_valid pattern 1,0,0,1
    for (int i = 0; i < 200 && nd_cnt < 3; i++) step((i % 4 == 0) || (i % 4 == 3));
    chk("reach_nd", nd_cnt, 3);
    wait_fs(3);

    // Missing done -> sticky timeout
    done = 1'b0;
    wait_nd(4, 1'b1);
    for (int i = 0; i < 60 && !to0; i++) step(1'b0);
    chk("to_set", {to0, to1}, 2'b11);
    chk("to_fill", {s_ready0, busy0}, 2'b10);
    chk("to_no_fs", fs_cnt, 3);
    done = 1'b1;
    wait_nd(5, 1'b1);
    wait_fs(4);
    chk("to_sticky", {to0, to1}, 2'b11);

    // Reset in the middle of a burst
    wait_nd(6, 1'b1);
    for (int i = 0; i < 30 && !(busy0 && addr0 == 4'd5); i++) step(1'b0);
    chk("at_idx5", {busy0, addr0, addr1}, {1'b1, 4'd5, 4'd10});
    #2 rst = 1'b1;
    fq.delete();
    #1;
    chk("mid_rst_outs", {new_data0, busy0, to0, fs0, addr0, addr1}, 0);
    chk("mid_rst_data", {dre0, dim0}, 0);
    chk("mid_rst_ready", {s_ready0, s_ready1}, 2'b11);
    @(negedge clk);
    #2 rst = 1'b0;
    wait_nd(7, 1'b1);
    wait_fs(5);
    chk("total_fs", fs_cnt, 5);
    chk("total_nd", nd_cnt, 7);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
